// File: rtl/mmio_hub.sv
// MMIO hub for the 0xF000_0000 region: halt flag, NCH buffered UART TX channels,
// LED register and synchronised switch input, with registered read data.
module mmio_hub #(
  parameter int NCH        = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int LED_W      = 16,
  parameter int SW_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          mem_addr,
  input  logic [3:0]           mem_oe,
  input  logic [3:0]           mem_we,
  input  logic [31:0]          mem_wdata,
  output logic [31:0]          mmio_rdata,
  output logic                 mmio_valid,
  output logic                 halt,
  output logic [8*NCH-1:0]     tx_data,
  output logic [NCH-1:0]       tx_we,
  input  logic [NCH-1:0]       tx_ready,
  output logic [LED_W-1:0]     led,
  input  logic [SW_W-1:0]      sw,
  output logic [2*NCH-1:0]     dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } drain_state_e;

  logic        sel, wr, rd;
  logic [15:0] off;
  logic [3:0]  ch_idx;
  logic        ch_is_data, ch_is_ctrl;

  assign sel        = mem_oe[0] && (mem_addr[31:28] == 4'hf);
  assign wr         = sel && mem_we[0];
  assign rd         = sel && !mem_we[0];
  assign off        = mem_addr[15:0];
  assign ch_idx     = off[7:4];
  assign ch_is_data = (off[15:8] == 8'h01) && (off[3:0] == 4'h0);
  assign ch_is_ctrl = (off[15:8] == 8'h01) && (off[3:0] == 4'h4);

  logic unused_bits;
  assign unused_bits = ^{mem_addr[27:16], mem_oe[3:1], mem_we[3:1], mem_wdata};

  logic [31:0] ch_status [NCH];

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    drain_state_e  state_q, state_d;
    logic          tx_we_q, tx_we_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          hit, push, flush, full, empty, push_ok, pop, start;

    assign hit     = (ch_idx == 4'(c));
    assign push    = wr && ch_is_data && hit;
    assign flush   = wr && ch_is_ctrl && hit;
    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    // A flush cancels any send that would otherwise start this cycle.
    assign start   = !empty && tx_ready[c] && !flush;

    always_comb begin
      state_d   = state_q;
      tx_we_d   = 1'b0;
      tx_data_d = tx_data_q;
      pop       = 1'b0;
      case (state_q)
        ST_IDLE, ST_WAIT: begin
          if (start) begin
            state_d   = ST_SEND;
            tx_we_d   = 1'b1;
            tx_data_d = fifo_mem[rd_ptr_q];
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SEND: begin
          pop     = 1'b1;
          state_d = ST_WAIT;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Fullness is judged on the registered count, so a same-cycle pop never frees a slot.
    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (flush) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
        ovf_d    = 1'b0;
      end else begin
        if (pop)          rd_ptr_d = rd_ptr_q + AW'(1);
        if (push_ok)      wr_ptr_d = wr_ptr_q + AW'(1);
        if (push && full) ovf_d    = 1'b1;
        count_d = count_q + CW'(push_ok) - CW'(pop);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr_q  <= '0;
        rd_ptr_q  <= '0;
        count_q   <= '0;
        ovf_q     <= 1'b0;
        state_q   <= ST_IDLE;
        tx_we_q   <= 1'b0;
        tx_data_q <= '0;
      end else begin
        wr_ptr_q  <= wr_ptr_d;
        rd_ptr_q  <= rd_ptr_d;
        count_q   <= count_d;
        ovf_q     <= ovf_d;
        state_q   <= state_d;
        tx_we_q   <= tx_we_d;
        tx_data_q <= tx_data_d;
      end
    end

    always_ff @(posedge clk) begin
      if (push_ok) fifo_mem[wr_ptr_q] <= mem_wdata[7:0];
    end

    assign tx_we[c]            = tx_we_q;
    assign tx_data[8*c +: 8]   = tx_data_q;
    assign dbg_state[2*c +: 2] = state_q;
    assign ch_status[c]        = {16'h0, 8'(count_q), 6'h0, ovf_q, ~full};
  end

  logic             halt_q, halt_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [SW_W-1:0]  sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
  logic             mmio_valid_q, mmio_valid_d;
  logic [31:0]      mmio_rdata_q, mmio_rdata_d;
  logic [31:0]      rd_val;

  always_comb begin
    rd_val = '0;
    if (off == 16'h0000) begin
      rd_val = {31'b0, halt_q};
    end else if (ch_is_data || ch_is_ctrl) begin
      for (int i = 0; i < NCH; i++) begin
        if (ch_idx == 4'(i)) rd_val = ch_status[i];
      end
    end else if (off == 16'h0200) begin
      rd_val[LED_W-1:0] = led_q;
    end else if (off == 16'h0300) begin
      rd_val[SW_W-1:0] = sw_sync_q;
    end
  end

  always_comb begin
    halt_d       = halt_q | (wr && (off == 16'h0000));
    led_d        = (wr && (off == 16'h0200)) ? mem_wdata[LED_W-1:0] : led_q;
    sw_meta_d    = sw;
    sw_sync_d    = sw_meta_q;
    mmio_valid_d = rd;
    mmio_rdata_d = rd ? rd_val : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      halt_q       <= 1'b0;
      led_q        <= '0;
      sw_meta_q    <= '0;
      sw_sync_q    <= '0;
      mmio_valid_q <= 1'b0;
      mmio_rdata_q <= '0;
    end else begin
      halt_q       <= halt_d;
      led_q        <= led_d;
      sw_meta_q    <= sw_meta_d;
      sw_sync_q    <= sw_sync_d;
      mmio_valid_q <= mmio_valid_d;
      mmio_rdata_q <= mmio_rdata_d;
    end
  end

  assign halt       = halt_q;
  assign led        = led_q;
  assign mmio_valid = mmio_valid_q;
  assign mmio_rdata = mmio_rdata_q;

endmodule
